sum_uart_tx: RTL and testbench

//   Downstream stage of the 8-bit operand adder. Takes each sum word over a valid/ready

---
 rtl/sum_uart_tx.sv | 95 +++++++++
 tb/tb_sum_uart_tx.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/sum_uart_tx.sv
// sum_uart_tx: serialises each accepted sum word as an 8N1-style UART frame (start, DATA_W bits LSB first, stop)
module sum_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_W       = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              tx,
   output logic              busy,
   output logic              frame_done
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] CMAX = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IMAX = IW'(DATA_W - 1);
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
   state_t            st_q, st_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [DATA_W-1:0] sh_q, sh_d;
   logic              tx_q, tx_d, rdy_q, rdy_d, busy_q, busy_d, done_q, done_d;
   logic              wrap;
   assign wrap       = cnt_q == CMAX;
   assign in_ready   = rdy_q;
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign frame_done = done_q;
   // state and registered outputs; reset parks the line idle and abandons any frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q   <= IDLE;
         cnt_q  <= '0;
         idx_q  <= '0;
         sh_q   <= '0;
         tx_q   <= 1'b1;
         rdy_q  <= 1'b1;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         sh_q   <= sh_d;
         tx_q   <= tx_d;
         rdy_q  <= rdy_d;
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end
   // next state: baud counter wraps every CLKS_PER_BIT cycles, each wrap advances one bit period
   always_comb begin
      st_d   = st_q;
      cnt_d  = (st_q == IDLE || wrap) ? '0 : cnt_q + CW'(1);
      idx_d  = idx_q;
      sh_d   = sh_q;
      tx_d   = tx_q;
      rdy_d  = rdy_q;
      busy_d = busy_q;
      done_d = 1'b0;
      case (st_q)
         IDLE: if (in_valid && rdy_q) begin
            st_d   = START;
            sh_d   = in_data;
            idx_d  = '0;
            tx_d   = 1'b0;
            rdy_d  = 1'b0;
            busy_d = 1'b1;
         end
         START: if (wrap) begin
            st_d = DATA;
            tx_d = sh_q[0];
            sh_d = sh_q >> 1;
         end
         DATA: if (wrap) begin
            if (idx_q == IMAX) begin
               st_d = STOP;
               tx_d = 1'b1;
            end else begin
               idx_d = idx_q + IW'(1);
               tx_d  = sh_q[0];
               sh_d  = sh_q >> 1;
            end
         end
         STOP: if (wrap) begin
            st_d   = IDLE;
            rdy_d  = 1'b1;
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      endcase
   end
endmodule

// File: tb/tb_sum_uart_tx.sv
// tb_sum_uart_tx: directed and random frames checked against a bit-period model of the UART line
module tb_sum_uart_tx;
   localparam int C = 4;
   localparam int W = 8;
   localparam int FL = (W + 2) * C;
   logic         clk = 1'b0, clk_en = 1'b0, rst;
   logic [W-1:0] in_data;
   logic         in_valid, in_ready, tx, busy, frame_done;
   int           checks = 0, errors = 0, cyc = 0, acc_cyc = 0;

   sum_uart_tx #(.CLKS_PER_BIT(C), .DATA_W(W)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .tx(tx), .busy(busy), .frame_done(frame_done)
   );

   always #5 if (clk_en) clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expects in_valid=1/in_data=d driven and the block idle; checks the whole frame cycle by cycle.
   task automatic frame(input logic [W-1:0] d, input bit hold, input int mid,
                        input logic [W-1:0] nxt, input bit gap_chk);
      logic [W+1:0] fr;
      logic [W-1:0] rx;
      fr = {1'b1, d, 1'b0};
      rx = '0;
      chk("ready_before", in_ready, 1);
      @(posedge clk);
      @(negedge clk);
      if (gap_chk) chk("start_gap", cyc - acc_cyc, FL + 1);
      acc_cyc = cyc;
      in_valid = hold;
      if (hold) in_data = nxt;
      for (int j = 0; j < FL; j++) begin
         if (j > 0) @(negedge clk);
         if (j == mid) begin
            in_valid = 1'b1;
            in_data  = nxt;
         end
         chk("tx_bit", tx, fr[j / C]);
         chk("ready_busy", in_ready, 0);
         chk("busy", busy, 1);
         chk("done_early", frame_done, 0);
         if (j % C == C / 2 && j / C >= 1 && j / C <= W) rx[j / C - 1] = tx;
      end
      @(negedge clk);
      chk("rx_byte", rx, d);
      chk("done_pulse", frame_done, 1);
      chk("ready_end", in_ready, 1);
      chk("busy_end", busy, 0);
      chk("tx_idle", tx, 1);
   endtask

   initial begin
      logic [W-1:0] a, b, s, cur, nx;
      bit h, ph;
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      #3;
      chk("rst_tx", tx, 1);
      chk("rst_ready", in_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", frame_done, 0);
      clk_en = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_tx", tx, 1);
      chk("idle_ready", in_ready, 1);
      // single 0xA5 pulse
      in_data = 8'hA5;
      in_valid = 1'b1;
      frame(8'hA5, 1'b0, -1, 8'h00, 1'b0);
      @(negedge clk);
      chk("done_one_cycle", frame_done, 0);
      chk("idle_after", tx, 1);
      // back-to-back 0x00 then 0xFF
      in_data = 8'h00;
      in_valid = 1'b1;
      frame(8'h00, 1'b1, -1, 8'hFF, 1'b0);
      frame(8'hFF, 1'b0, -1, 8'h00, 1'b1);
      @(negedge clk);
      // 0x3C offered mid-frame of 0x81
      in_data = 8'h81;
      in_valid = 1'b1;
      frame(8'h81, 1'b0, FL / 2, 8'h3C, 1'b0);
      frame(8'h3C, 1'b0, -1, 8'h00, 1'b1);
      @(negedge clk);
      // reset during data bit 3 of 0x5A
      in_data = 8'h5A;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4 * C + 1) @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_tx", tx, 1);
      chk("async_ready", in_ready, 1);
      chk("async_busy", busy, 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_no_done", frame_done, 0);
      end
      rst = 1'b0;
      in_data = 8'hC3;
      in_valid = 1'b1;
      frame(8'hC3, 1'b0, -1, 8'h00, 1'b0);
      @(negedge clk);
      // adder result with carry out dropped
      a = 8'hF0;
      b = 8'h20;
      s = a + b;
      in_data = s;
      in_valid = 1'b1;
      frame(s, 1'b0, -1, 8'h00, 1'b0);
      // random words, randomly back-to-back or with idle gaps
      cur = W'($urandom);
      in_data = cur;
      in_valid = 1'b1;
      ph = 1'b0;
      for (int i = 0; i < 6; i++) begin
         nx = W'($urandom);
         h = (i < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
         frame(cur, h, -1, nx, ph);
         if (!h && i < 5) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            chk("rand_idle_done", frame_done, 0);
            in_data = nx;
            in_valid = 1'b1;
         end
         ph = h;
         cur = nx;
      end
      in_valid = 1'b0;
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
